// File: rtl/manchester_frame_rx.sv
// manchester_frame_rx
//   Decoder for the Manchester-coded counter readout link. Hunts for the
//   leading '1' of the sync header, which shows up as a long high run. It then
//   checks the rest of the header and shifts in LENGTH payload bits, MSB first.
//   The decoder re-aligns on every accepted mid-bit transition.
//
// Ports
//   clk           receiver clock (oversamples the line)
//   rst_n         asynchronous active-low reset
//   ena           decoder enable; low forces HUNT and suppresses outputs
//   rx_in         asynchronous Manchester line
//   data          payload of the last good frame (held)
//   data_valid    one-cycle pulse when data updates
//   sync_error    one-cycle pulse on header mismatch
//   timeout_error one-cycle pulse on a missing mid-bit transition
//   busy          high while in SYNC or DATA
module manchester_frame_rx #(
    parameter int unsigned LENGTH          = 20,
    parameter int unsigned HALF_BIT_CYCLES = 4,
    parameter logic [3:0]  SYNC_PATTERN    = 4'b1010
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              rx_in,
    output logic [LENGTH-1:0] data,
    output logic              data_valid,
    output logic              sync_error,
    output logic              timeout_error,
    output logic              busy
);

    localparam int unsigned H  = HALF_BIT_CYCLES;
    localparam int unsigned CW = $clog2(4 * H) + 1;
    localparam int unsigned BW = $clog2(LENGTH);

    // Counters hold (cycles since edge - 1), so the thresholds below are
    // one less than the nominal run/window lengths.
    localparam logic [CW-1:0] RUN_MIN = CW'(3 * H / 2 - 1);
    localparam logic [CW-1:0] W_LO    = CW'(3 * H / 2 - 1);
    localparam logic [CW-1:0] W_HI    = CW'(5 * H / 2 - 1);
    localparam logic [BW-1:0] LAST    = BW'(LENGTH - 1);

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        DATA
    } state_t;

    state_t state, state_n;

    logic              s1, s2, s3;
    logic [2:0]        smp_vld;
    logic [CW-1:0]     run_cnt;
    logic              high_run;
    logic [CW-1:0]     w;
    logic [1:0]        idx;
    logic [BW-1:0]     cnt;
    logic [LENGTH-1:0] shreg;

    logic edge_det, rise, fall, bit_val;
    logic hunt_lock, mid_edge, win_expired, hdr_mismatch, last_bit;
    logic dv_n, se_n, te_n;

    // ------------------------------------------------------------------
    // Input synchronizer and edge detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            smp_vld <= '0;
        end else begin
            s1      <= rx_in;
            s2      <= s1;
            s3      <= s2;
            smp_vld <= {smp_vld[1:0], 1'b1};
        end
    end

    assign edge_det = s2 ^ s3;
    assign rise     = edge_det & s2;
    assign fall     = edge_det & ~s2;
    // The level before the mid-bit edge is the bit value.
    assign bit_val  = s3;

    // ------------------------------------------------------------------
    // Run counter. high_run marks a high run that began with a genuine
    // rising edge; a rise against the reset value of s3 does not count.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt  <= '0;
            high_run <= 1'b0;
        end else begin
            if (edge_det)
                run_cnt <= '0;
            else if (run_cnt != '1)
                run_cnt <= run_cnt + CW'(1);

            if (rise)
                high_run <= smp_vld[2];
            else if (fall)
                high_run <= 1'b0;
        end
    end

    assign hunt_lock    = fall && high_run && (run_cnt >= RUN_MIN);
    assign mid_edge     = edge_det && (w >= W_LO) && (w <= W_HI);
    assign win_expired  = !mid_edge && (w >= W_HI);
    assign hdr_mismatch = (bit_val != SYNC_PATTERN[idx]);
    assign last_bit     = (cnt == LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= HUNT;
        else
            state <= state_n;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        if (!ena) begin
            state_n = HUNT;
        end else begin
            case (state)
                HUNT: if (hunt_lock) state_n = SYNC;
                SYNC: begin
                    if (mid_edge) begin
                        if (hdr_mismatch)
                            state_n = HUNT;
                        else if (idx == 2'd0)
                            state_n = DATA;
                    end else if (win_expired) begin
                        state_n = HUNT;
                    end
                end
                DATA: begin
                    if ((mid_edge && last_bit) || win_expired)
                        state_n = HUNT;
                end
                default: state_n = HUNT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (pulses are registered below)
    // ------------------------------------------------------------------
    always_comb begin
        dv_n = 1'b0;
        se_n = 1'b0;
        te_n = 1'b0;
        busy = ena && (state == SYNC || state == DATA);
        if (ena) begin
            case (state)
                SYNC: begin
                    se_n = mid_edge && hdr_mismatch;
                    te_n = win_expired;
                end
                DATA: begin
                    dv_n = mid_edge && last_bit;
                    te_n = win_expired;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: window counter, header index, payload shifter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w             <= '0;
            idx           <= 2'd2;
            cnt           <= '0;
            shreg         <= '0;
            data          <= '0;
            data_valid    <= 1'b0;
            sync_error    <= 1'b0;
            timeout_error <= 1'b0;
        end else begin
            data_valid    <= dv_n;
            sync_error    <= se_n;
            timeout_error <= te_n;

            // In HUNT w is held at 0, so it starts fresh right after the lock edge.
            if (state == HUNT || mid_edge)
                w <= '0;
            else if (w != '1)
                w <= w + CW'(1);

            case (state)
                HUNT: idx <= 2'd2;
                SYNC: begin
                    cnt   <= '0;
                    shreg <= '0;
                    if (mid_edge)
                        idx <= idx - 2'd1;
                end
                DATA: begin
                    if (mid_edge) begin
                        shreg <= {shreg[LENGTH-2:0], bit_val};
                        cnt   <= cnt + BW'(1);
                    end
                end
                default: ;
            endcase

            if (dv_n)
                data <= {shreg[LENGTH-2:0], bit_val};
        end
    end

endmodule

// File: tb/tb_manchester_frame_rx.sv
// tb_manchester_frame_rx
//   Scoreboard bench: the transmitter tasks push the expected pulse (kind,
//   data, cycle) when they drive the deciding mid-bit transition; a negedge
//   monitor pops and compares every pulse the decoder produces.
module tb_manchester_frame_rx;

    localparam int H = 4;
    localparam int L = 20;

    localparam int K_VALID   = 0;
    localparam int K_SYNC    = 1;
    localparam int K_TIMEOUT = 2;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena   = 1'b0;
    logic         rx_in = 1'b0;
    logic [L-1:0] data;
    logic         data_valid, sync_error, timeout_error, busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int np;
    int kind_obs;

    typedef struct {
        int           kind;
        logic [L-1:0] d;
        int           at;
    } exp_t;

    exp_t         q[$];
    exp_t         e;
    logic [L-1:0] last_good = '0;
    int           tri_j[4]  = '{0, 1, 0, -1};

    manchester_frame_rx #(
        .LENGTH         (L),
        .HALF_BIT_CYCLES(H),
        .SYNC_PATTERN   (4'b1010)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .rx_in        (rx_in),
        .data         (data),
        .data_valid   (data_valid),
        .sync_error   (sync_error),
        .timeout_error(timeout_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            np = int'(data_valid) + int'(sync_error) + int'(timeout_error);
            if (np != 0) begin
                kind_obs = data_valid ? K_VALID : (sync_error ? K_SYNC : K_TIMEOUT);
                check("pulse_exclusive", np, 1);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got kind %0d data %0h at cycle %0d, expected none",
                             kind_obs, data, cyc);
                end else begin
                    e = q.pop_front();
                    check("pulse_kind", kind_obs, e.kind);
                    check("pulse_cycle", cyc, e.at);
                    check("pulse_data", data, e.d);
                end
            end
        end
    end

    // Drives one half-bit level for dur cycles; always entered 1 time unit after posedge.
    task automatic drive_half(input logic lvl, input int dur);
        rx_in = lvl;
        repeat (dur) @(posedge clk);
        #1;
    endtask

    // Sends n bits MSB first. When the mid-bit of bit exp_idx is driven, the
    // expected pulse is pushed, due exp_lat cycles later.
    task automatic send_bits(input logic [63:0] bits, input int n, input bit jit,
                             input int exp_idx, input int exp_kind, input int exp_lat,
                             input logic [L-1:0] exp_d);
        logic b;
        int   k, dur;
        for (int i = 0; i < n; i++) begin
            b = bits[n-1-i];
            for (int h = 0; h < 2; h++) begin
                k   = 2 * i + h;
                dur = H;
                if (jit) dur = H + tri_j[(k+1)%4] - tri_j[k%4];
                if (h == 1 && i == exp_idx) q.push_back('{exp_kind, exp_d, cyc + exp_lat});
                drive_half((h == 1) ? ~b : b, dur);
            end
        end
    endtask

    task automatic idle(input int n);
        send_bits('0, n, 1'b0, -1, 0, 0, '0);
    endtask

    // Full 24-bit frame; expectation derived from the header against 1010.
    task automatic frame(input logic [3:0] hdr, input logic [L-1:0] p, input bit jit);
        logic [3:0] ref_sync;
        int         bad;
        ref_sync = 4'b1010;
        bad      = -1;
        for (int j = 2; j >= 0; j--)
            if (bad < 0 && hdr[j] != ref_sync[j]) bad = 3 - j;
        if (bad >= 0) begin
            send_bits({hdr, p}, 24, jit, bad, K_SYNC, 3, last_good);
        end else begin
            send_bits({hdr, p}, 24, jit, 23, K_VALID, 3, p);
            last_good = p;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", data, 0);
        check("reset_pulses", {data_valid, sync_error, timeout_error}, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        ena   = 1'b1;

        // Basic frame
        idle(8);
        frame(4'b1010, 20'hABCDE, 1'b0);
        idle(4);
        check("busy_after_frame", busy, 0);

        // Bad header
        idle(8);
        frame(4'b1011, 20'hFFFFF, 1'b0);
        idle(4);
        check("data_after_sync_err", data, 20'hABCDE);

        // Timeout: line stuck high after data bit 5, then a frame straight after
        idle(8);
        send_bits({4'b1010, 6'b110010}, 10, 1'b0, 9, K_TIMEOUT, 13, last_good);
        drive_half(1'b1, 30);
        check("busy_after_timeout", busy, 0);
        frame(4'b1010, 20'h00001, 1'b0);
        idle(4);

        // Back-to-back with one 0 bit between
        idle(8);
        frame(4'b1010, 20'h12345, 1'b0);
        idle(1);
        frame(4'b1010, 20'hFFFFF, 1'b0);
        idle(4);

        // All-zero stream, then a jittered frame
        idle(24);
        frame(4'b1010, 20'h5A5A5, 1'b1);
        idle(4);

        // ena dropped mid-frame
        idle(8);
        send_bits({4'b1010, 8'hA5}, 12, 1'b0, -1, 0, 0, '0);
        check("busy_mid_frame", busy, 1);
        ena = 1'b0;
        @(negedge clk);
        check("busy_ena_low", busy, 0);
        @(posedge clk);
        #1;
        send_bits({12'h3C3}, 12, 1'b0, -1, 0, 0, '0);
        idle(8);
        ena = 1'b1;
        idle(4);
        check("data_after_ena_low", data, 20'h5A5A5);
        frame(4'b1010, 20'h13579, 1'b0);
        idle(4);

        // Async reset mid-DATA
        idle(8);
        send_bits({4'b1010, 6'b101010}, 10, 1'b0, -1, 0, 0, '0);
        check("busy_before_reset", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_data", data, 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_pulses", {data_valid, sync_error, timeout_error}, 0);
        last_good = '0;
        rx_in     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(8);
        frame(4'b1010, 20'hC3C3C, 1'b0);
        idle(4);

        repeat (20) @(posedge clk);
        check("scoreboard_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
